// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, parity/stop/overrun checks.
// Optional RX_MAJORITY_VOTE_EN: 3-sample majority per sample point, decided one clock late.
module uart_rx_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [18:0] k,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        clr_rxrdy,
    output logic [7:0]  data,
    output logic        rxrdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic        rx_meta, rxs;
    logic [18:0] tc, tc_next;
    logic [3:0]  bc, bc_next;
    logic [9:0]  sr, sr_next;
    logic        armed, armed_next;
    logic        samp;
    logic [18:0] start_pt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic rxs_h1, rxs_h2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxs_h1 <= 1'b1;
            rxs_h2 <= 1'b1;
        end else begin
            rxs_h1 <= rxs;
            rxs_h2 <= rxs_h1;
        end
    end

    // Decision lands one clock after the nominal point; tc reload moves with it.
    assign samp     = (rxs & rxs_h1) | (rxs & rxs_h2) | (rxs_h1 & rxs_h2);
    assign start_pt = (k >> 1) + 19'd1;
`else
    assign samp     = rxs;
    assign start_pt = k >> 1;
`endif

    // Right-justify the shifted frame: data, optional bit 7, optional parity, stop.
    logic [1:0] shamt;
    logic [9:0] frame;
    logic [3:0] stop_idx;
    logic [7:0] rx_data;
    logic       par_bit, new_perr, new_ferr;

    always_comb begin
        shamt    = 2'd2 - {1'b0, eight} - {1'b0, pen};
        frame    = sr >> shamt;
        stop_idx = 4'd7 + {3'b0, eight} + {3'b0, pen};
        rx_data  = {eight & frame[7], frame[6:0]};
        par_bit  = eight ? frame[8] : frame[7];
        new_perr = pen & (par_bit != ((^rx_data) ^ ohel));
        new_ferr = ~frame[stop_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tc    <= '0;
            bc    <= '0;
            sr    <= '1;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            tc    <= tc_next;
            bc    <= bc_next;
            sr    <= sr_next;
            armed <= armed_next;
        end
    end

    always_comb begin
        state_next = state;
        tc_next    = tc + 19'd1;
        bc_next    = bc;
        sr_next    = sr;
        armed_next = armed;
        case (state)
            IDLE: begin
                // armed needs one rxs=1 clock so a low line after a bad stop cannot restart
                tc_next    = '0;
                armed_next = armed | rxs;
                if (armed && !rxs) begin
                    state_next = START;
                    armed_next = 1'b0;
                end
            end
            START: begin
                if (tc == start_pt) begin
                    tc_next = '0;
                    if (!samp) begin
                        bc_next    = 4'd8 + {3'b0, eight} + {3'b0, pen};
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (tc == k - 19'd1) begin
                    tc_next = '0;
                    sr_next = {samp, sr[9:1]};
                    bc_next = bc - 4'd1;
                    if (bc == 4'd1)
                        state_next = DONE;
                end
            end
            DONE: begin
                tc_next    = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == DONE) begin
            data  <= rx_data;
            rxrdy <= 1'b1;
            // a coinciding read consumes the old flags; the new character's flags survive
            if (clr_rxrdy) begin
                perr <= new_perr;
                ferr <= new_ferr;
                ovf  <= 1'b0;
            end else begin
                perr <= perr | new_perr;
                ferr <= ferr | new_ferr;
                ovf  <= ovf | rxrdy;
            end
        end else if (clr_rxrdy) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: format table plus hand-built corner sequences.
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        reset, rx, eight, pen, ohel, clr_rxrdy;
    logic [18:0] k;
    logic [7:0]  data;
    logic        rxrdy, perr, ferr, ovf;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int KB = 16;

    uart_rx_engine dut (
        .clk(clk), .reset(reset), .rx(rx), .k(k), .eight(eight), .pen(pen),
        .ohel(ohel), .clr_rxrdy(clr_rxrdy), .data(data), .rxrdy(rxrdy),
        .perr(perr), .ferr(ferr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int   total = 0, passed = 0;
    int   cyc = 0, rise_cyc = 0, start_cyc = 0;
    logic rdy_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= rxrdy;
        if (rxrdy && !rdy_q)
            rise_cyc <= cyc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int clr_at, input int glitch_at, input logic tail);
        logic [11:0] v;
        int pos, nb;
        v    = '1;
        v[0] = 1'b0;
        for (int b = 0; b < 7; b++) v[b+1] = d[b];
        pos = 8;
        if (eight) begin v[pos] = d[7]; pos++; end
        if (pen)   begin v[pos] = par;  pos++; end
        v[pos] = stop;
        nb = pos + 1;
        for (int i = 0; i < nb * KB; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            rx        = (i == glitch_at) ? 1'b1 : v[i / KB];
            clr_rxrdy = (i == clr_at);
        end
        @(negedge clk);
        rx        = tail;
        clr_rxrdy = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_rxrdy = 1'b1;
        @(negedge clk); clr_rxrdy = 1'b0;
    endtask

    function automatic int exp_lat(input logic e, input logic p);
        return KB * (8 + int'(e) + int'(p)) + 13 + EXTRA;
    endfunction

    typedef struct {
        logic       e, p, o;
        logic [7:0] d;
        logic       par, stop;
        logic [7:0] xd;
        logic       xperr, xferr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};

        reset = 1'b1; rx = 1'b1; clr_rxrdy = 1'b0; k = 19'd16;
        eight = 1'b1; pen = 1'b1; ohel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {data, rxrdy, perr, ferr, ovf}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int n = 0; n < 9; n++) begin
            eight = vecs[n].e; pen = vecs[n].p; ohel = vecs[n].o;
            repeat (2) @(negedge clk);
            send_frame(vecs[n].d, vecs[n].par, vecs[n].stop, -1, -1, 1'b1);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_data", n), data, vecs[n].xd);
            check($sformatf("v%0d_rxrdy", n), rxrdy, 1'b1);
            check($sformatf("v%0d_perr", n), perr, vecs[n].xperr);
            check($sformatf("v%0d_ferr", n), ferr, vecs[n].xferr);
            check($sformatf("v%0d_ovf", n), ovf, 1'b0);
            check($sformatf("v%0d_latency", n), rise_cyc - start_cyc, exp_lat(vecs[n].e, vecs[n].p));
            pulse_clr();
            @(negedge clk);
            check($sformatf("v%0d_cleared", n), {rxrdy, perr, ferr, ovf}, 4'b0);
        end

        // framing error with the line left low: no restart until rx returns high
        eight = 1'b0; pen = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, -1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("lowline_ferr", {data, ferr}, {8'h55, 1'b1});
        pulse_clr();
        repeat (200) @(negedge clk);
        check("lowline_no_restart", rxrdy, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h11, 1'b0, 1'b1, -1, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("lowline_recover", {data, rxrdy, ferr}, {8'h11, 1'b1, 1'b0});
        pulse_clr();

        // false start, then overrun
        eight = 1'b1; pen = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start", {rxrdy, perr, ferr, ovf}, 4'b0);
        send_frame(8'h01, 1'b0, 1'b1, -1, -1, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1, -1, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("ovf_data", data, 8'h02);
        check("ovf_flags", {rxrdy, ovf, ferr, perr}, 4'b1100);

        // reset midway through data bits of 8'h3C
        for (int i = 0; i < KB * 5 + 8; i++) begin
            @(negedge clk);
            rx = (i < KB) ? 1'b0 : ((i / KB == 3 || i / KB == 4) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midframe_reset", {data, rxrdy, perr, ferr, ovf}, 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b1, -1, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("post_reset_frame", {data, rxrdy, ovf, ferr}, {8'h3C, 1'b1, 1'b0, 1'b0});
        check("post_reset_latency", rise_cyc - start_cyc, exp_lat(1'b1, 1'b0));

        // read clear coinciding with DONE of a new character
        pulse_clr();
        send_frame(8'h81, 1'b0, 1'b0, -1, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("collide_prev_ferr", {rxrdy, ferr}, 2'b11);
        send_frame(8'h42, 1'b0, 1'b1, KB * 9 + 12 + EXTRA, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("collide_data", data, 8'h42);
        check("collide_flags", {rxrdy, ovf, ferr, perr}, 4'b1000);

        // one-clock high glitch exactly on the data bit 3 sample
        pulse_clr();
        send_frame(8'h00, 1'b0, 1'b1, -1, KB * 4 + 9, 1'b1);
        repeat (4) @(negedge clk);
`ifdef RX_MAJORITY_VOTE_EN
        check("glitch_data", data, 8'h00);
`else
        check("glitch_data", data, 8'h08);
`endif
        check("glitch_rxrdy", rxrdy, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

- Receive side of the UART: recovers serial characters from `rx` in the frame format the transmitter builds.
- Frame: start 0, 7 data bits LSB first, an optional 8th data bit, optional parity, stop 1.
- The format is selected by the same `eight`, `pen` and `ohel` controls the transmit decode uses. The block checks parity, stop and overrun, and presents the character to the processor interface with a ready flag and sticky error flags.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idles at 1.
- `k`  in  19  clocks per bit time; valid range 4..2^19-1; must be held static while not IDLE.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  1 = parity bit present and checked.
- `ohel`  in  1  0 = even parity, 1 = odd parity.
- `clr_rxrdy`  in  1  one-clock pulse issued when the processor reads the character; clears `rxrdy`, `perr`, `ferr` and `ovf`.
- `data`  out  8  received character; bit 7 is forced to 0 when `eight`=0.
- `rxrdy`  out  1  character available.
- `perr`  out  1  parity error (sticky).
- `ferr`  out  1  framing error: stop bit sampled as 0 (sticky).
- `ovf`  out  1  overrun: a new character completed while `rxrdy`=1 (sticky).

## Operation
- Synchronization: `rx` passes through a 2-flop synchronizer (`rxs`); all logic uses `rxs`.
- Bit counter: `bc` counts the remaining bits; it is loaded with 8+`eight`+`pen` on start confirmation. That count covers the 7 data bits, `eight`, `pen` and the stop bit.
- Time counter: `tc` is 19 bits; it reloads to 0 at each sample point.
- State IDLE:
  - Wait for `rxs`=0.
  - Then clear `tc` and go to START.
- State START:
  - At `tc` = `k`>>1 (mid start bit), sample `rxs`.
  - If 0: clear `tc`, load `bc`, go to SHIFT.
  - If 1: false start; return to IDLE with no flag change.
- State SHIFT:
  - At `tc` = `k`-1, sample `rxs` and shift it into a 10-bit register `sr` from bit 9 (shift right); decrement `bc`.
  - When `bc` reaches 0, go to DONE.
- Realignment: after the last shift, `sr` is right-justified by shifting 2-`eight`-`pen` more places. The result is data[6:0], then data[7] if `eight`, then parity if `pen`, then stop.
- State DONE (one clock), then return to IDLE:
  - `data` ← received data bits, with bit 7 forced to 0 when `eight`=0.
  - `perr` ← `pen` & (received parity ≠ (^data bits over 7 or 8 bits) ^ `ohel`).
  - `ferr` ← stop bit == 0.
  - `ovf` ← `rxrdy` (value before this update).
  - `rxrdy` ← 1.
  - `perr` and `ferr` are OR-ed into the sticky flags, not overwritten.
- Register updates: `data` and the flags update only in DONE. A second character overwrites `data`.
- Read clear: `clr_rxrdy` clears `rxrdy`, `perr`, `ferr` and `ovf` on the next edge.
- Read/DONE collision: if `clr_rxrdy` coincides with DONE, DONE wins. `rxrdy`=1, `ovf`=0, and the flags take the new character's values.
- Framing error with line held low: a `ferr` frame with `rx` still low does not restart until `rxs` returns to 1. IDLE requires `rxs`=1 for one clock before accepting a new start.
- Reset mid-frame:
  - Asynchronously forces IDLE, `tc`=0, `bc`=0, `sr`=10'h3FF.
  - All outputs go to 0; the partially received character is discarded.

## Timing
- Reset values: `data`=8'h00, `rxrdy`=0, `perr`=0, `ferr`=0, `ovf`=0.
- Synchronizer latency: 2 clocks from `rx` to `rxs`.
- Start confirmation: `k`>>1 clocks after `rxs` falls.
- Data samples: each at `k` clocks after the previous sample, i.e. near mid-bit.
- Ready latency: `rxrdy` and the flags assert 1 clock after the stop-bit sample (DONE).
- Back-to-back frames: supported. The receiver is in IDLE before the next start edge can arrive, because the stop sample occurs at mid-stop-bit.

## Configuration
- Macro: `RX_MAJORITY_VOTE_EN`.
- Defined: each sample point (start confirmation and every SHIFT sample) takes the majority of `rxs` at sample offsets -1, 0 and +1 clocks.
  - The decision is made at offset +1.
  - The following `tc` reference shifts with it, so bit spacing stays `k`.
  - All latencies above grow by 1 clock.
- Undefined: single sample at offset 0.

## Test plan
- Format `eight`=1, `pen`=1, `ohel`=0, `k`=16; send 8'hA5 with parity bit 0 and stop 1 → `data`=8'hA5, `rxrdy`=1, `perr`=`ferr`=`ovf`=0, asserted 1 clock after the stop sample.
- Same format but `ohel`=1 with parity bit 0 → `perr`=1 and `data`=8'hA5. Then pulse `clr_rxrdy` → all flags 0.
- Format `eight`=0, `pen`=0, `k`=16; send 7'h55 with stop 0 → `data`=8'h55, `ferr`=1. No new frame starts until `rx` returns high.
- Pulse `rx` low for 6 clocks (`k`=16) → false start, return to IDLE, `rxrdy` stays 0. Then receive two frames 8'h01 and 8'h02 without `clr_rxrdy` → `data`=8'h02, `ovf`=1.
- Assert `reset` midway through the data bits → all outputs 0 immediately. Then receive 8'h3C cleanly → `data`=8'h3C.
- With `RX_MAJORITY_VOTE_EN`: a 1-clock high glitch at the mid-point of data bit 3 of 8'h00 → `data`=8'h00. Without the macro, the same stimulus gives `data`=8'h08.
